dram_model: RTL and testbench
=============================

DRAM_MODEL -- requirements
Module: dram_model

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, byte-address width.
REQ-002 SHALL have parameter WORD_SIZE, default 32, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of words stored.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from request acceptance to DATA_READY; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port ENABLE  input  1  access request from DLX data stage.
REQ-008 SHALL have port READNOTWRITE  input  1  1 = read, 0 = write; sampled with ENABLE.
REQ-009 SHALL have port ADDRESS  input  ADDR_SIZE  byte address; sampled with ENABLE.
REQ-010 SHALL have port WDATA  input  WORD_SIZE  store data; sampled with ENABLE.
REQ-011 SHALL have port RDATA  output  WORD_SIZE  load data.
REQ-012 SHALL have port DATA_READY  output  1  one-cycle completion pulse.
REQ-013 SHALL have port ERROR  output  1  access fault, valid only while DATA_READY=1.
REQ-014 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 IDLE with ENABLE=1 at a rising edge SHALL latch ADDRESS, READNOTWRITE, WDATA and load the latency counter with LATENCY-1.
REQ-017 On acceptance, SHALL go to DONE if LATENCY=1, else to WAIT.
REQ-018 WAIT SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reaches 1.
REQ-019 DATA_READY SHALL be high exactly in the DONE cycle, i.e. LATENCY cycles after the accepting edge.
REQ-020 DONE SHALL unconditionally go to IDLE on the next edge; requests are accepted only in IDLE, so minimum spacing is LATENCY+1 cycles.
REQ-021 ENABLE SHALL be ignored in WAIT and DONE; deasserting it mid-access SHALL NOT abort the access.
REQ-022 The word index SHALL be latched ADDRESS[ADDR_SIZE-1:2].
REQ-023 The access SHALL be faulty if latched ADDRESS[1:0] != 0 or the word index >= DEPTH.
REQ-024 A good write SHALL update the array on the edge that enters DONE.
REQ-025 A good read SHALL load RDATA from the array on the edge that enters DONE.
REQ-026 RDATA SHALL hold its value until the next completed read and SHALL be unaffected by writes.
REQ-027 A faulty access SHALL NOT modify the array, SHALL drive RDATA=0 if it is a read, and SHALL drive ERROR=1 in the DONE cycle.
REQ-028 ERROR SHALL be 0 outside DONE.
REQ-029 A read from a word written by the immediately preceding access SHALL return the new data.
REQ-030 Word index arithmetic SHALL NOT wrap: indices >= DEPTH are faults, never aliased.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, counter=0, DATA_READY=0, ERROR=0, BUSY=0, RDATA=0.
REQ-032 Reset asserted during WAIT or DONE SHALL abandon the pending access with no array write and no DATA_READY.
REQ-033 The storage array SHALL NOT be cleared by reset; contents persist across reset.
REQ-034 After rst deassertion, a request SHALL be accepted at the first rising edge with ENABLE=1.

Verification
REQ-035 Write, then read, with LATENCY=2: write 0xDEADBEEF to 0x10 -> DATA_READY 2 cycles after the accepting edge, ERROR=0; read 0x10 -> RDATA=0xDEADBEEF with DATA_READY.
REQ-036 Misaligned access, ADDRESS=0x13: read -> DATA_READY with ERROR=1, RDATA=0; write 0x1 -> ERROR=1, and a later read of 0x10 still returns 0xDEADBEEF.
REQ-037 Out-of-range access, DEPTH=64, ADDRESS=0x100: -> ERROR=1 and no aliasing; a read of 0x0 is unchanged.
REQ-038 ENABLE held high continuously -> accepted every LATENCY+1 cycles; DATA_READY pulses are one cycle wide; BUSY=0 only in accepting cycles.
REQ-039 rst=0 pulse one cycle after a write to 0x20 is accepted -> no DATA_READY; 0x20 keeps its old value; RDATA=0 and BUSY=0 asynchronously.
REQ-040 LATENCY=1 sweep: read of 0x4 accepted at edge k -> DATA_READY in cycle k+1, IDLE in cycle k+2.

Source files
------------

// File: rtl/dram_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dram_model : word-addressed memory with fixed access latency and fault flag |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dram_model #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ENABLE,
  input  logic                 READNOTWRITE,
  input  logic [ADDR_SIZE-1:0] ADDRESS,
  input  logic [WORD_SIZE-1:0] WDATA,
  output logic [WORD_SIZE-1:0] RDATA,
  output logic                 DATA_READY,
  output logic                 ERROR,
  output logic                 BUSY
);

  localparam int                 c_IDX_W  = ADDR_SIZE - 2;
  localparam int                 c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]         c_LAT_M1 = 4'(LATENCY - 1);
  localparam logic [c_IDX_W-1:0] c_DEPTH  = c_IDX_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state, w_state_next;
  logic [3:0]             r_cnt, w_cnt_next;
  logic                   r_rnw;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_rdata;
  logic                   r_err;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];

  logic                   w_accept;
  logic                   w_enter_done;
  logic                   w_rnw;
  logic [ADDR_SIZE-1:0]   w_addr;
  logic [WORD_SIZE-1:0]   w_wdata;
  logic [c_IDX_W-1:0]     w_idx;
  logic [c_AW-1:0]        w_midx;
  logic                   w_fault;

  // With LATENCY=1 the edge that accepts also completes, so the live inputs
  // must be used instead of the not-yet-latched copies.
  assign w_accept     = (r_state == IDLE) && ENABLE;
  assign w_rnw        = w_accept ? READNOTWRITE : r_rnw;
  assign w_addr       = w_accept ? ADDRESS      : r_addr;
  assign w_wdata      = w_accept ? WDATA        : r_wdata;
  assign w_idx        = w_addr[ADDR_SIZE-1:2];
  assign w_midx       = w_idx[c_AW-1:0];
  assign w_fault      = (w_addr[1:0] != 2'b00) || (w_idx >= c_DEPTH);
  assign w_enter_done = (w_state_next == DONE) && (r_state != DONE);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (ENABLE) begin
          w_state_next = (c_LAT_M1 == 4'd0) ? DONE : WAIT;
          w_cnt_next   = c_LAT_M1;
        end
      end
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_next = DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rnw   <= READNOTWRITE;
        r_addr  <= ADDRESS;
        r_wdata <= WDATA;
      end
      if (w_enter_done) begin
        r_err <= w_fault;
        if (w_rnw) begin
          r_rdata <= w_fault ? '0 : r_mem[w_midx];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && w_enter_done && !w_rnw && !w_fault) begin
      r_mem[w_midx] <= w_wdata;
    end
  end

  assign RDATA      = r_rdata;
  assign DATA_READY = (r_state == DONE);
  assign ERROR      = (r_state == DONE) && r_err;
  assign BUSY       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dram_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dram_model : directed self-checking bench for dram_model (LATENCY 2, 1)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dram_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, rnw;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err, busy;
  logic        l1_en, l1_rnw;
  logic [31:0] l1_addr, l1_wdata;
  logic [31:0] l1_rdata;
  logic        l1_ready, l1_err, l1_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_model #(.ADDR_SIZE(32), .WORD_SIZE(32), .DEPTH(64), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .ENABLE(en), .READNOTWRITE(rnw), .ADDRESS(addr),
    .WDATA(wdata), .RDATA(rdata), .DATA_READY(ready), .ERROR(err), .BUSY(busy)
  );

  dram_model #(.ADDR_SIZE(32), .WORD_SIZE(32), .DEPTH(64), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .ENABLE(l1_en), .READNOTWRITE(l1_rnw), .ADDRESS(l1_addr),
    .WDATA(l1_wdata), .RDATA(l1_rdata), .DATA_READY(l1_ready), .ERROR(l1_err), .BUSY(l1_busy)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access on the LATENCY=2 instance; returns at the first idle cycle.
  task automatic access(input logic is_read, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int edges,
                        output logic seen);
    @(negedge clk);
    en = 1'b1; rnw = is_read; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    edges = 0;
    while (!ready && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    seen = ready; rd = rdata; e = err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e, seen, any_ready;
    int          edges;
    logic [8:0]  rdy_v, busy_v;

    rst = 1'b1; en = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
    l1_en = 1'b0; l1_rnw = 1'b0; l1_addr = '0; l1_wdata = '0;
    #1 rst = 1'b0;
    #2;
    check_value("reset_ready", {31'b0, ready}, 32'd0);
    check_value("reset_error", {31'b0, err}, 32'd0);
    check_value("reset_busy",  {31'b0, busy}, 32'd0);
    check_value("reset_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    access(1'b0, 32'h10, 32'hDEAD_BEEF, rd, e, edges, seen);
    check_value("wr10_seen", {31'b0, seen}, 32'd1);
    check_value("wr10_lat",  edges, 32'd1);
    check_value("wr10_err",  {31'b0, e}, 32'd0);
    access(1'b1, 32'h10, 32'h0, rd, e, edges, seen);
    check_value("rd10_data", rd, 32'hDEAD_BEEF);
    check_value("rd10_err",  {31'b0, e}, 32'd0);
    check_value("rd10_lat",  edges, 32'd1);
    check_value("idle_busy",  {31'b0, busy}, 32'd0);
    check_value("idle_ready", {31'b0, ready}, 32'd0);

    access(1'b1, 32'h13, 32'h0, rd, e, edges, seen);
    check_value("rd13_err",  {31'b0, e}, 32'd1);
    check_value("rd13_data", rd, 32'd0);
    check_value("err_outside_done", {31'b0, err}, 32'd0);
    access(1'b0, 32'h13, 32'h1, rd, e, edges, seen);
    check_value("wr13_err",  {31'b0, e}, 32'd1);
    access(1'b1, 32'h10, 32'h0, rd, e, edges, seen);
    check_value("rd10_after_mis", rd, 32'hDEAD_BEEF);

    access(1'b0, 32'h0, 32'h1234_5678, rd, e, edges, seen);
    check_value("wr0_err",    {31'b0, e}, 32'd0);
    check_value("rdata_hold", rdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h100, 32'h0000_0BAD, rd, e, edges, seen);
    check_value("wr100_err",  {31'b0, e}, 32'd1);
    access(1'b1, 32'h0, 32'h0, rd, e, edges, seen);
    check_value("rd0_no_alias", rd, 32'h1234_5678);
    access(1'b1, 32'h100, 32'h0, rd, e, edges, seen);
    check_value("rd100_err",  {31'b0, e}, 32'd1);
    check_value("rd100_data", rd, 32'd0);

    // ENABLE held high: accept, WAIT, DONE, accept again ...
    @(negedge clk);
    en = 1'b1; rnw = 1'b1; addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rdy_v[i]  = ready;
      busy_v[i] = busy;
    end
    en = 1'b0;
    check_value("stream_ready", {23'b0, rdy_v},  {23'b0, 9'b010010010});
    check_value("stream_busy",  {23'b0, busy_v}, {23'b0, 9'b011011011});
    @(posedge clk); #1;
    check_value("stream_end_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a write must abandon it.
    access(1'b0, 32'h20, 32'hAAAA_5555, rd, e, edges, seen);
    access(1'b1, 32'h10, 32'h0, rd, e, edges, seen);
    check_value("pre_rst_rdata", rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    en = 1'b1; rnw = 1'b0; addr = 32'h20; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    en = 1'b0;
    check_value("mid_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("async_rdata", rdata, 32'd0);
    check_value("async_busy",  {31'b0, busy}, 32'd0);
    check_value("async_ready", {31'b0, ready}, 32'd0);
    any_ready = 1'b0;
    @(posedge clk); #1;
    any_ready |= ready;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      any_ready |= ready;
    end
    check_value("rst_no_ready", {31'b0, any_ready}, 32'd0);
    access(1'b1, 32'h20, 32'h0, rd, e, edges, seen);
    check_value("rd20_kept", rd, 32'hAAAA_5555);

    // LATENCY=1 instance: DATA_READY right after the accepting edge.
    @(negedge clk);
    l1_en = 1'b1; l1_rnw = 1'b0; l1_addr = 32'h4; l1_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    l1_en = 1'b0;
    check_value("l1_wr_ready", {31'b0, l1_ready}, 32'd1);
    check_value("l1_wr_err",   {31'b0, l1_err}, 32'd0);
    @(posedge clk); #1;
    check_value("l1_wr_idle",  {31'b0, l1_busy}, 32'd0);
    @(negedge clk);
    l1_en = 1'b1; l1_rnw = 1'b1; l1_addr = 32'h4;
    @(posedge clk); #1;
    l1_en = 1'b0;
    check_value("l1_rd_ready", {31'b0, l1_ready}, 32'd1);
    check_value("l1_rd_data",  l1_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check_value("l1_rd_idle_busy",  {31'b0, l1_busy}, 32'd0);
    check_value("l1_rd_idle_ready", {31'b0, l1_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
